// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter slice.
package wb_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int DATA_W     = 32;

  // One pending register-file write: destination, bank select, payload.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic                  fbank;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_t;

  // Integer register 0 is hard-wired, so writes to it can be suppressed;
  // the float bank has a real register 0 and is always written.
  function automatic logic wb_write_en(input wb_entry_t e, input logic zero_discard);
    return !(zero_discard && !e.fbank && (e.waddr == {REG_ADDR_W{1'b0}}));
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bus bundle between the result producers, the arbiter and the register file.
interface writeback_arbiter_if
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_reg;
  logic                  pipe_float;
  logic [DATA_W-1:0]     pipe_data;
  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [REG_ADDR_W-1:0] mdu_reg;
  logic                  mdu_float;
  logic [DATA_W-1:0]     mdu_data;
  logic                  stall;
  logic [REG_ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0]     writeData;
  logic                  regWrite;
  logic                  float;
  logic [CNT_W-1:0]      fifo_count;

  modport master (
    output pipe_valid, pipe_reg, pipe_float, pipe_data,
    output mdu_valid, mdu_reg, mdu_float, mdu_data,
    input  mdu_ready, stall, writeReg, writeData, regWrite, float, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_reg, pipe_float, pipe_data,
    input  mdu_valid, mdu_reg, mdu_float, mdu_data,
    output mdu_ready, stall, writeReg, writeData, regWrite, float, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering MDU results until the write port is free.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  wb_entry_t        din_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  // Never overrun or underrun, even if a caller misbehaves.
  assign push_ok_s = push_i && (count_q != FULL_CNT);
  assign pop_ok_s  = pop_i && (count_q != ZERO_CNT);

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= ZERO_CNT;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the main pipeline and buffered MDU results onto one register-file
// write port, with an anti-starvation stall for the MDU side.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int MAX_WAIT     = 8,
  parameter int ZERO_DISCARD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_arbiter_if.slave  bus
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic              ZD       = (ZERO_DISCARD != 0);

  logic [CNT_W-1:0]      count_s;
  wb_entry_t             head_s, pipe_entry_s, mdu_entry_s, sel_entry_s;
  wb_src_t               src_s;
  logic                  push_s, pop_s, stall_s, ready_s;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  wfloat_q, wen_q;

  assign pipe_entry_s = {bus.pipe_reg, bus.pipe_float, bus.pipe_data};
  assign mdu_entry_s  = {bus.mdu_reg, bus.mdu_float, bus.mdu_data};

  // Ready comes from the registered count only: a same-cycle pop does not help.
  assign ready_s = (count_s < FULL_CNT);
  assign push_s  = bus.mdu_valid && ready_s;
  assign stall_s = (count_s != ZERO_CNT) && (wait_q == WAIT_MAX);
  assign pop_s   = (src_s == SRC_FIFO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (mdu_entry_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  // Source priority: forced drain, then main pipeline, then opportunistic drain.
  always_comb begin
    src_s = SRC_NONE;
    if (stall_s)                   src_s = SRC_FIFO;
    else if (bus.pipe_valid)       src_s = SRC_PIPE;
    else if (count_s != ZERO_CNT)  src_s = SRC_FIFO;
    else                           src_s = SRC_NONE;
  end

  // Payload mux for the selected source.
  always_comb begin
    sel_entry_s = head_s;
    case (src_s)
      SRC_PIPE: sel_entry_s = pipe_entry_s;
      SRC_FIFO: sel_entry_s = head_s;
      default:  sel_entry_s = head_s;
    endcase
  end

  // Starvation age of the FIFO head, saturating at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if ((count_s == ZERO_CNT) || pop_s) wait_d = {WAIT_W{1'b0}};
    else if (wait_q != WAIT_MAX)        wait_d = wait_q + WAIT_W'(1);
    else                                wait_d = wait_q;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= {WAIT_W{1'b0}};
    else        wait_q <= wait_d;
  end

  // Output register toward the register file; payload holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg_q   <= {REG_ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      wfloat_q <= 1'b0;
      wen_q    <= 1'b0;
    end else if (src_s != SRC_NONE) begin
      wreg_q   <= sel_entry_s.waddr;
      wdata_q  <= sel_entry_s.data;
      wfloat_q <= sel_entry_s.fbank;
      wen_q    <= wb_write_en(sel_entry_s, ZD);
    end else begin
      wen_q    <= 1'b0;
    end
  end

  assign bus.mdu_ready  = ready_s;
  assign bus.stall      = stall_s;
  assign bus.writeReg   = wreg_q;
  assign bus.writeData  = wdata_q;
  assign bus.float      = wfloat_q;
  assign bus.regWrite   = wen_q;
  assign bus.fifo_count = count_s;

endmodule
